// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Synthesizable snapshot reader for a NUM_REGS x DATA_W register file. A start
// pulse walks the register file two entries at a time through its two
// combinational read ports and streams every value out, one word per
// valid/ready handshake, to a debug or trace sink. busy stays high for the
// whole dump so the pipeline can hold off register writes and the snapshot
// stays consistent.
//
// Optional feature (compile-time macro DUMP_CHECKSUM_EN):
//   When defined, a final extra word carrying the XOR of all dumped registers
//   is appended (dump_index = 0, dump_last = 1) and done follows it.
//   When undefined, the stream is exactly NUM_REGS words.
//
// Parameters:
//   NUM_REGS  number of registers to dump (even, >= 2)
//   DATA_W    register width in bits
//   ADDR_W    register index width (2**ADDR_W >= NUM_REGS)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        one-cycle dump request, honoured only when idle
//   abort        synchronous cancel, back to idle without a done pulse
//   read_reg1/2  indices driven to the register file read ports
//   read_data1/2 combinational data returned by the read ports
//   dump_valid   output word valid
//   dump_ready   sink accepts the word
//   dump_data    register value
//   dump_index   register number of dump_data
//   dump_last    marks the final word of the stream
//   busy         high whenever a dump is in progress
//   done         one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_index,
    output logic              dump_last,
    output logic              busy,
    output logic              done
);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND0, S_SEND1, S_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SEND0, S_SEND1
    } state_t;
`endif

    // Base index of the final pair; idx_q carries one extra bit so that
    // idx_q + 2 never wraps before it is compared.
    localparam logic [ADDR_W:0] LAST_PAIR = (ADDR_W+1)'(NUM_REGS - 2);

    state_t            state_q;
    logic [ADDR_W:0]   idx_q;
    logic [DATA_W-1:0] buf0_q;
    logic [DATA_W-1:0] buf1_q;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] acc_q;
`endif
    logic [ADDR_W-1:0] read_reg1_q;
    logic [ADDR_W-1:0] read_reg2_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;

    logic              handshake;
    logic              last_pair;
    logic [ADDR_W:0]   idx_next;
    logic [ADDR_W-1:0] idx_lo;

    assign handshake = valid_q && dump_ready;
    assign last_pair = (idx_q == LAST_PAIR);
    assign idx_next  = idx_q + (ADDR_W+1)'(2);
    assign idx_lo    = idx_q[ADDR_W-1:0];

    // Output word is selected straight from the capture buffers, which only
    // change in FETCH, so data and index stay stable during backpressure.
    // NOTE: every signal written in always_comb gets a default first so no
    // latch is inferred on the states that do not drive it.
    always_comb begin
        dump_data  = '0;
        dump_index = '0;
        case (state_q)
            S_SEND0: begin
                dump_data  = buf0_q;
                dump_index = idx_lo;
            end
            S_SEND1: begin
                dump_data  = buf1_q;
                dump_index = idx_lo + ADDR_W'(1);
            end
`ifdef DUMP_CHECKSUM_EN
            S_CSUM: begin
                dump_data  = acc_q;
                dump_index = '0;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the capture buffers are plain registers, not a RAM, so
            // they are reset along with the control state.
            state_q     <= S_IDLE;
            idx_q       <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
`ifdef DUMP_CHECKSUM_EN
            acc_q       <= '0;
`endif
            read_reg1_q <= '0;
            read_reg2_q <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                // Abort beats both start and a same-cycle handshake.
                state_q     <= S_IDLE;
                read_reg1_q <= '0;
                read_reg2_q <= '0;
                valid_q     <= 1'b0;
                last_q      <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q     <= S_FETCH;
                            idx_q       <= '0;
                            read_reg1_q <= '0;
                            read_reg2_q <= ADDR_W'(1);
                            busy_q      <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                            acc_q       <= '0;
`endif
                        end
                    end
                    S_FETCH: begin
                        buf0_q  <= read_data1;
                        buf1_q  <= read_data2;
`ifdef DUMP_CHECKSUM_EN
                        acc_q   <= acc_q ^ read_data1 ^ read_data2;
`endif
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= S_SEND0;
                    end
                    S_SEND0: begin
                        if (handshake) begin
                            state_q <= S_SEND1;
`ifdef DUMP_CHECKSUM_EN
                            last_q  <= 1'b0;
`else
                            last_q  <= last_pair;
`endif
                        end
                    end
                    S_SEND1: begin
                        if (handshake) begin
                            if (last_pair) begin
`ifdef DUMP_CHECKSUM_EN
                                state_q     <= S_CSUM;
                                last_q      <= 1'b1;
`else
                                state_q     <= S_IDLE;
                                read_reg1_q <= '0;
                                read_reg2_q <= '0;
                                valid_q     <= 1'b0;
                                last_q      <= 1'b0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
`endif
                            end else begin
                                state_q     <= S_FETCH;
                                idx_q       <= idx_next;
                                read_reg1_q <= idx_next[ADDR_W-1:0];
                                read_reg2_q <= ADDR_W'(idx_next + (ADDR_W+1)'(1));
                                valid_q     <= 1'b0;
                                last_q      <= 1'b0;
                            end
                        end
                    end
`ifdef DUMP_CHECKSUM_EN
                    S_CSUM: begin
                        if (handshake) begin
                            state_q     <= S_IDLE;
                            read_reg1_q <= '0;
                            read_reg2_q <= '0;
                            valid_q     <= 1'b0;
                            last_q      <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign read_reg1  = read_reg1_q;
    assign read_reg2  = read_reg2_q;
    assign dump_valid = valid_q;
    assign dump_last  = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_regfile_dump_reader
//
// Directed bench for regfile_dump_reader. A behavioural register file feeds
// the read ports; every started dump pushes its expected word stream into a
// scoreboard queue, and each accepted handshake pops and compares one entry.
// Also covers reset values, latency, backpressure hold, start while busy,
// abort, async reset mid-dump and (with DUMP_CHECKSUM_EN) the checksum word.
// -----------------------------------------------------------------------------
module tb_regfile_dump_reader;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXTRA    = 1;
`else
    localparam int EXTRA    = 0;
`endif
    localparam int DONE_CYC = 3 * NUM_REGS / 2 + 1 + EXTRA;
    localparam int WORDS    = NUM_REGS + EXTRA;

    typedef struct {
        logic [ADDR_W-1:0] index;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic [ADDR_W-1:0] dump_index;
    logic              dump_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NUM_REGS];

    assign read_data1 = regs[read_reg1];
    assign read_data2 = regs[read_reg2];

    regfile_dump_reader #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_data  (dump_data),
        .dump_index (dump_index),
        .dump_last  (dump_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t              sb [$];
    int                checks;
    int                errors;
    int                cyc;
    int                busy_cnt;
    int                done_cnt;
    int                done_cyc;
    int                words;
    bit                hold_pending;
    logic [DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0] hold_index;
    logic              hold_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sampled at the falling edge: stability under backpressure, busy/done
    // bookkeeping and scoreboard comparison of every accepted word.
    task automatic monitor();
        exp_t e;
        if (!rst_n) return;
        if (hold_pending) begin
            check("hold_data", 64'(dump_data), 64'(hold_data));
            check("hold_index", 64'(dump_index), 64'(hold_index));
            check("hold_last", 64'(dump_last), 64'(hold_last));
        end
        hold_pending = dump_valid && !dump_ready && !abort;
        hold_data    = dump_data;
        hold_index   = dump_index;
        hold_last    = dump_last;
        if (busy) busy_cnt++;
        if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        if (dump_valid && dump_ready && !abort) begin
            words++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow: observed index %0d expected no word", dump_index);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("word_index", 64'(dump_index), 64'(e.index));
                check("word_data", 64'(dump_data), 64'(e.data));
                check("word_last", 64'(dump_last), 64'(e.last));
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_expected();
        exp_t e;
        logic [DATA_W-1:0] x;
        x = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            e.index = ADDR_W'(i);
            e.data  = regs[i];
            e.last  = (EXTRA == 0) && (i == NUM_REGS - 1);
            sb.push_back(e);
            x = x ^ regs[i];
        end
        if (EXTRA != 0) begin
            e.index = '0;
            e.data  = x;
            e.last  = 1'b1;
            sb.push_back(e);
        end
    endtask

    // Drives start in cycle 0; returns just after the edge that opens cycle 1.
    task automatic start_dump();
        sb.delete();
        hold_pending = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        words    = 0;
        push_expected();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_index(input int idx);
        int n;
        n = 0;
        while (!(dump_valid && dump_index == ADDR_W'(idx)) && n < 200) begin
            cycle();
            n++;
        end
        check("wait_index", {63'(dump_index), dump_valid}, {63'(idx), 1'b1});
    endtask

    task automatic run_to_done(input int exp_done);
        while (done_cnt == 0 && cyc < 400) cycle();
        for (int i = 0; i < 3; i++) cycle();
        check("done_cycle", 64'(done_cyc), 64'(exp_done));
        check("done_count", 64'(done_cnt), 64'd1);
        check("busy_cycles", 64'(busy_cnt), 64'(exp_done - 1));
        check("word_count", 64'(words), 64'(WORDS));
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        dump_ready = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(i * 3);

        // Reset values
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(dump_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_last", 64'(dump_last), 64'd0);
        check("rst_data", 64'(dump_data), 64'd0);
        check("rst_index", 64'(dump_index), 64'd0);
        check("rst_rr1", 64'(read_reg1), 64'd0);
        check("rst_rr2", 64'(read_reg2), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic dump with latency checks
        start_dump();
        check("c1_busy", 64'(busy), 64'd1);
        check("c1_valid", 64'(dump_valid), 64'd0);
        check("c1_rr1", 64'(read_reg1), 64'd0);
        check("c1_rr2", 64'(read_reg2), 64'd1);
        cycle();
        check("c2_valid", 64'(dump_valid), 64'd1);
        check("c2_index", 64'(dump_index), 64'd0);
        run_to_done(DONE_CYC);
        check("idle_busy", 64'(busy), 64'd0);

        // Backpressure: stall 5 cycles on index 7
        start_dump();
        wait_index(7);
        dump_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_data", 64'(dump_data), 64'd21);
            check("stall_index", 64'(dump_index), 64'd7);
            cycle();
        end
        dump_ready = 1'b1;
        run_to_done(DONE_CYC + 5);

        // Start while busy is ignored
        start_dump();
        wait_index(10);
        start = 1'b1;
        cycle();
        start = 1'b0;
        run_to_done(DONE_CYC);

        // Abort during SEND1 of index 13, with ready high
        start_dump();
        wait_index(12);
        cycle();
        check("abort_at13", 64'(dump_index), 64'd13);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(dump_valid), 64'd0);
        check("abort_rr1", 64'(read_reg1), 64'd0);
        for (int i = 0; i < 5; i++) cycle();
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_words", 64'(words), 64'd13);
        // start together with abort in IDLE stays IDLE
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'd0);
        cycle();
        check("start_abort_rr2", 64'(read_reg2), 64'd0);
        // fresh start restarts at index 0
        start_dump();
        cycle();
        check("restart_index", 64'(dump_index), 64'd0);
        run_to_done(DONE_CYC);

        // Async reset in FETCH
        start_dump();
        check("pre_rst_rr2", 64'(read_reg2), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_valid", 64'(dump_valid), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_rr1", 64'(read_reg1), 64'd0);
        check("arst_rr2", 64'(read_reg2), 64'd0);
        sb.delete();
        hold_pending = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        cycle();
        check("arst_no_done", 64'(done), 64'd0);

`ifdef DUMP_CHECKSUM_EN
        // Checksum word: XOR of r5 and r9 only
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;
        regs[5] = 32'hA5A5A5A5;
        regs[9] = 32'h0F0F0F0F;
        start_dump();
        check("csum_model", 64'(sb[NUM_REGS].data), 64'hAAAAAAAA);
        run_to_done(DONE_CYC);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
